// File: rtl/procom_pkg.sv
// Shared helpers for the conv datapath frame buffers: FSM encoding,
// address-width calculation and output-frame dimension derivation.
package procom_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        READOUT = 1'b1
    } state_t;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Valid-convolution output size along one axis.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

endpackage

// File: rtl/conv_frame_collector_bram_sdp.sv
// Simple dual-port RAM: one write port, one read port with a registered
// one-cycle read that holds its value when no read is issued.
module bram_sdp
    import procom_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we_i,
    input  logic [clogb2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       re_i,
    input  logic [clogb2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]           rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_frame_collector.sv
// Collects one convolved output frame into BRAM, then lets the host drain it.
// Build option: define RESULT_CLAMP_EN to saturate results instead of truncating.
module conv_frame_collector
    import procom_pkg::*;
#(
    parameter int RAM_WIDTH    = 8,
    parameter int IN_WIDTH     = 20,
    parameter int IMAGE_WIDTH  = 10,
    parameter int IMAGE_HEIGHT = 10,
    parameter int KERNEL_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_conv_valid,
    input  logic signed [IN_WIDTH-1:0]  i_conv_data,
    input  logic                        i_read_valid,
    output logic [RAM_WIDTH-1:0]        o_data_from_mem,
    output logic                        o_read_valid,
    output logic                        o_frame_ready,
    output logic                        o_overflow
);

    localparam int OUT_W = out_dim(IMAGE_WIDTH, KERNEL_WIDTH);
    localparam int OUT_H = out_dim(IMAGE_HEIGHT, KERNEL_WIDTH);
    localparam int DEPTH = OUT_W * OUT_H;
    localparam int AW    = clogb2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

`ifdef RESULT_CLAMP_EN
    localparam logic signed [IN_WIDTH-1:0] PIX_MAX = IN_WIDTH'((1 << RAM_WIDTH) - 1);

    function automatic logic [RAM_WIDTH-1:0] conv_to_pix(input logic signed [IN_WIDTH-1:0] d);
        if (d < 0) begin
            return '0;
        end else if (d > PIX_MAX) begin
            return '1;
        end
        return RAM_WIDTH'(d);
    endfunction
`else
    function automatic logic [RAM_WIDTH-1:0] conv_to_pix(input logic signed [IN_WIDTH-1:0] d);
        return RAM_WIDTH'(d);
    endfunction
`endif

    state_t            state_q;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic              frame_ready_q;
    logic              read_valid_q;
    logic              overflow_q;
    logic              wr_en;
    logic              rd_en;
    logic [RAM_WIDTH-1:0] pix;

    assign wr_en     = (state_q == COLLECT) && i_conv_valid;
    assign rd_en     = (state_q == READOUT) && i_read_valid;
    assign pix       = conv_to_pix(i_conv_data);
    assign wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
    assign rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= COLLECT;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            frame_ready_q <= 1'b0;
            read_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    read_valid_q <= 1'b0;
                    if (i_conv_valid) begin
                        wr_addr_q <= wr_addr_d;
                        if (wr_addr_q == LAST_ADDR) begin
                            state_q       <= READOUT;
                            frame_ready_q <= 1'b1;
                        end
                    end
                end
                READOUT: begin
                    read_valid_q <= i_read_valid;
                    // Frame not yet drained: incoming pixels are lost.
                    if (i_conv_valid) begin
                        overflow_q <= 1'b1;
                    end
                    if (i_read_valid) begin
                        rd_addr_q <= rd_addr_d;
                        if (rd_addr_q == LAST_ADDR) begin
                            state_q       <= COLLECT;
                            frame_ready_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    bram_sdp #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (DEPTH)
    ) u_bram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_en),
        .waddr_i (wr_addr_q),
        .wdata_i (pix),
        .re_i    (rd_en),
        .raddr_i (rd_addr_q),
        .rdata_o (o_data_from_mem)
    );

    assign o_read_valid  = read_valid_q;
    assign o_frame_ready = frame_ready_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_conv_frame_collector.sv
// Directed bench for conv_frame_collector (default 10x10 image, 3x3 kernel, 64-pixel frame).
module tb_conv_frame_collector;

    localparam int RAM_WIDTH = 8;
    localparam int IN_WIDTH  = 20;

    logic                       clk;
    logic                       reset;
    logic                       i_conv_valid;
    logic signed [IN_WIDTH-1:0] i_conv_data;
    logic                       i_read_valid;
    logic [RAM_WIDTH-1:0]       o_data_from_mem;
    logic                       o_read_valid;
    logic                       o_frame_ready;
    logic                       o_overflow;

    int total;
    int bad;

    conv_frame_collector #(
        .RAM_WIDTH    (RAM_WIDTH),
        .IN_WIDTH     (IN_WIDTH),
        .IMAGE_WIDTH  (10),
        .IMAGE_HEIGHT (10),
        .KERNEL_WIDTH (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_conv_valid    (i_conv_valid),
        .i_conv_data     (i_conv_data),
        .i_read_valid    (i_read_valid),
        .o_data_from_mem (o_data_from_mem),
        .o_read_valid    (o_read_valid),
        .o_frame_ready   (o_frame_ready),
        .o_overflow      (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One valid cycle followed by one idle cycle; returns at a falling edge.
    task automatic write_pix(input int v);
        @(negedge clk);
        i_conv_valid = 1'b1;
        i_conv_data  = IN_WIDTH'(v);
        @(negedge clk);
        i_conv_valid = 1'b0;
    endtask

    // One strobe; the pixel is visible at the next falling edge.
    task automatic read_pix(input string tag, input int exp);
        @(negedge clk);
        i_read_valid = 1'b1;
        @(negedge clk);
        i_read_valid = 1'b0;
        chk({tag, "_rv"}, 32'(o_read_valid), 32'd1);
        chk({tag, "_data"}, 32'(o_data_from_mem), 32'(exp));
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        i_conv_valid = 1'b0;
        i_conv_data  = '0;
        i_read_valid = 1'b0;

        // 1: reset state
        repeat (5) @(negedge clk);
        chk("rst_frame_ready", 32'(o_frame_ready), 32'd0);
        chk("rst_read_valid", 32'(o_read_valid), 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        chk("rst_data", 32'(o_data_from_mem), 32'd0);
        reset = 1'b0;

        // 2: ramp frame and full readout
        for (int i = 0; i < 63; i++) write_pix(i);
        chk("t2_ready_before_last", 32'(o_frame_ready), 32'd0);
        write_pix(63);
        chk("t2_ready_after_last", 32'(o_frame_ready), 32'd1);
        read_pix("t2_px0", 0);
        @(negedge clk);
        chk("t2_idle_rv", 32'(o_read_valid), 32'd0);
        chk("t2_hold_data", 32'(o_data_from_mem), 32'd0);
        for (int i = 1; i < 64; i++) read_pix("t2_px", i);
        chk("t2_ready_after_drain", 32'(o_frame_ready), 32'd0);
        chk("t2_no_overflow", 32'(o_overflow), 32'd0);

        // 3: reduction of out-of-range results
        write_pix(300);
        write_pix(-5);
        for (int i = 2; i < 64; i++) write_pix(i);
        chk("t3_ready", 32'(o_frame_ready), 32'd1);
`ifdef RESULT_CLAMP_EN
        read_pix("t3_px0_clamp", 255);
        read_pix("t3_px1_clamp", 0);
`else
        read_pix("t3_px0_trunc", 44);
        read_pix("t3_px1_trunc", 251);
`endif
        for (int i = 2; i < 64; i++) read_pix("t3_px", i);

        // 4: extra pixel while frame is pending
        for (int i = 0; i < 64; i++) write_pix(i + 50);
        write_pix(99);
        chk("t4_overflow_set", 32'(o_overflow), 32'd1);
        chk("t4_still_ready", 32'(o_frame_ready), 32'd1);
        for (int i = 0; i < 64; i++) read_pix("t4_px", i + 50);
        chk("t4_overflow_sticky", 32'(o_overflow), 32'd1);
        chk("t4_ready_after_drain", 32'(o_frame_ready), 32'd0);

        // 5: read strobes during collection are ignored
        for (int i = 0; i < 20; i++) write_pix(i);
        @(negedge clk);
        i_read_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_no_rv", 32'(o_read_valid), 32'd0);
        end
        i_read_valid = 1'b0;
        chk("t5_not_ready", 32'(o_frame_ready), 32'd0);
        for (int i = 20; i < 64; i++) write_pix(i);
        chk("t5_ready", 32'(o_frame_ready), 32'd1);
        for (int i = 0; i < 64; i++) read_pix("t5_px", i);

        // 6: reset mid-frame, then a fresh frame with collisions at both ends
        for (int i = 0; i < 30; i++) write_pix(200 + i);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_ready", 32'(o_frame_ready), 32'd0);
        chk("t6_rst_overflow", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 63; i++) write_pix(100 + i);
        chk("t6_ready_before_last", 32'(o_frame_ready), 32'd0);
        @(negedge clk);
        i_conv_valid = 1'b1;
        i_conv_data  = IN_WIDTH'(163);
        i_read_valid = 1'b1;
        @(negedge clk);
        i_conv_valid = 1'b0;
        i_read_valid = 1'b0;
        chk("t6_ready_after_last", 32'(o_frame_ready), 32'd1);
        chk("t6_read_ignored", 32'(o_read_valid), 32'd0);
        for (int i = 0; i < 63; i++) read_pix("t6_px", 100 + i);
        @(negedge clk);
        i_read_valid = 1'b1;
        i_conv_valid = 1'b1;
        i_conv_data  = IN_WIDTH'(7);
        @(negedge clk);
        i_read_valid = 1'b0;
        i_conv_valid = 1'b0;
        chk("t6_last_rv", 32'(o_read_valid), 32'd1);
        chk("t6_last_data", 32'(o_data_from_mem), 32'd163);
        chk("t6_last_overflow", 32'(o_overflow), 32'd1);
        chk("t6_ready_after_drain", 32'(o_frame_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
